// File: rtl/seq_window_ctrl.sv
// seq_window_ctrl: windowed serial pattern detector.
// A window is opened by start, armed for one cycle, then counts valid input
// bits until the programmed window length is reached or stop is seen. Every
// occurrence of the programmed pattern inside the window is pulsed on
// detected_o and counted (saturating) in det_count_o.
//
// Build option: define DETECT_OVERLAP_EN to keep the history and fill state
// after a match, so that overlapping occurrences are also detected. Without it,
// a match restarts the fill count and the next match needs len fresh bits.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | waiting for start; configuration writes accepted here only
// ST_ARM  | one cycle: clear history, fill, window count, det_count, overflow
// ST_RUN  | shifting valid bits, matching, counting window bits
// ST_DONE | one cycle: done_o high, then back to idle

module seq_window_ctrl #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8,
    parameter int WIN_W   = 16
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               cfg_we_i,
    input  logic [MAX_LEN-1:0] cfg_pattern_i,
    input  logic [3:0]         cfg_len_i,
    input  logic [WIN_W-1:0]   cfg_window_i,
    input  logic               start_i,
    input  logic               stop_i,
    input  logic               din_i,
    input  logic               din_valid_i,
    output logic               busy_o,
    output logic               detected_o,
    output logic [CNT_W-1:0]   det_count_o,
    output logic               overflow_o,
    output logic               done_o
);

    localparam int FILL_W = $clog2(MAX_LEN + 1);
    localparam logic [MAX_LEN-1:0] PAT_ONE  = MAX_LEN'(1);
    localparam logic [FILL_W-1:0]  FILL_MAX = FILL_W'(MAX_LEN);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [3:0]         len_q, len_d;
    logic [WIN_W-1:0]   win_q, win_d;
    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic [WIN_W-1:0]   wcnt_q, wcnt_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic               det_q, det_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [3:0]         len_clamp;
    logic [MAX_LEN-1:0] hist_shift;
    logic [MAX_LEN-1:0] len_mask;
    logic [FILL_W-1:0]  fill_inc;
    logic [WIN_W-1:0]   wcnt_inc;
    logic               match;
    logic               win_hit;

    // Length 0 is meaningless and lengths beyond the history depth cannot match.
    assign len_clamp = (cfg_len_i == 4'd0)          ? 4'd1 :
                       (32'(cfg_len_i) > MAX_LEN)    ? 4'(MAX_LEN) : cfg_len_i;

    assign hist_shift = {hist_q[MAX_LEN-2:0], din_i};
    // len == MAX_LEN shifts the one out entirely, and the subtraction wraps to all-ones.
    assign len_mask   = (PAT_ONE << len_q) - PAT_ONE;
    assign fill_inc   = (fill_q == FILL_MAX) ? fill_q : fill_q + FILL_W'(1);

    // Window counter holds at the programmed length, or at all-ones when unbounded.
    assign wcnt_inc = (win_q == '0) ? ((&wcnt_q) ? wcnt_q : wcnt_q + WIN_W'(1))
                                    : ((wcnt_q == win_q) ? wcnt_q : wcnt_q + WIN_W'(1));

    assign match   = din_valid_i && (32'(fill_inc) >= 32'(len_q)) &&
                     ((hist_shift & len_mask) == (pat_q & len_mask));
    assign win_hit = din_valid_i && (win_q != '0) && (wcnt_inc == win_q);

    // Next-state and datapath update for the window sequencer.
    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        len_d   = len_q;
        win_d   = win_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        wcnt_d  = wcnt_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        det_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cfg_we_i) begin
                    pat_d = cfg_pattern_i;
                    len_d = len_clamp;
                    win_d = cfg_window_i;
                end
                if (start_i) state_d = ST_ARM;
            end
            ST_ARM: begin
                hist_d  = '0;
                fill_d  = '0;
                wcnt_d  = '0;
                cnt_d   = '0;
                ovf_d   = 1'b0;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (din_valid_i) begin
                    hist_d = hist_shift;
                    fill_d = fill_inc;
                    wcnt_d = wcnt_inc;
                    if (match) begin
                        det_d = 1'b1;
                        if (&cnt_q) ovf_d = 1'b1;
                        else        cnt_d = cnt_q + CNT_W'(1);
`ifdef DETECT_OVERLAP_EN
                        fill_d = fill_inc;
`else
                        fill_d = '0;
`endif
                    end
                end
                if (stop_i || win_hit) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_ARM) || (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    // State, configuration and registered outputs; reset aborts any open window.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            pat_q   <= '0;
            len_q   <= 4'd1;
            win_q   <= '0;
            hist_q  <= '0;
            fill_q  <= '0;
            wcnt_q  <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            det_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            win_q   <= win_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            wcnt_q  <= wcnt_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            det_q   <= det_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy_o      = busy_q;
    assign detected_o  = det_q;
    assign det_count_o = cnt_q;
    assign overflow_o  = ovf_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_seq_window_ctrl.sv
// Bench for seq_window_ctrl with a 2-bit detection counter so saturation is reachable.
module tb_seq_window_ctrl;

    localparam int CNT_MAX = 3;
`ifdef DETECT_OVERLAP_EN
    localparam bit OVL     = 1'b1;
    localparam int EXP_OVL = 2;
`else
    localparam bit OVL     = 1'b0;
    localparam int EXP_OVL = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_we = 1'b0;
    logic [7:0]  cfg_pattern = '0;
    logic [3:0]  cfg_len = '0;
    logic [15:0] cfg_window = '0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        din = 1'b0;
    logic        din_valid = 1'b0;
    logic        busy, detected, overflow, done;
    logic [1:0]  det_count;

    int n_checks = 0;
    int n_err = 0;
    int det_pulses = 0;
    int done_pulses = 0;

    seq_window_ctrl #(.MAX_LEN(8), .CNT_W(2), .WIN_W(16)) dut (
        .clk_i(clk), .rst_ni(rst_n), .cfg_we_i(cfg_we), .cfg_pattern_i(cfg_pattern),
        .cfg_len_i(cfg_len), .cfg_window_i(cfg_window), .start_i(start), .stop_i(stop),
        .din_i(din), .din_valid_i(din_valid), .busy_o(busy), .detected_o(detected),
        .det_count_o(det_count), .overflow_o(overflow), .done_o(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase 0 idle, 1 arming, 2 window open, 3 closing.
    int         m_phase = 0;
    logic [7:0] m_pat = '0;
    int         m_len = 1;
    int         m_win = 0;
    int         m_bits[$];
    int         m_wcnt = 0;
    int         m_cnt = 0;
    bit         m_ovf = 1'b0;
    bit         m_det = 1'b0;

    function automatic bit model_match();
        int n = m_bits.size();
        if (n < m_len) return 1'b0;
        for (int i = 0; i < m_len; i++)
            if (m_bits[n-1-i] != int'(m_pat[i])) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0; m_pat = '0; m_len = 1; m_win = 0;
            m_bits.delete(); m_wcnt = 0; m_cnt = 0; m_ovf = 1'b0; m_det = 1'b0;
        end else begin
            m_det = 1'b0;
            case (m_phase)
                0: begin
                    if (cfg_we) begin
                        m_pat = cfg_pattern;
                        m_len = (cfg_len == 0) ? 1 : ((int'(cfg_len) > 8) ? 8 : int'(cfg_len));
                        m_win = int'(cfg_window);
                    end
                    if (start) m_phase = 1;
                end
                1: begin
                    m_bits.delete(); m_wcnt = 0; m_cnt = 0; m_ovf = 1'b0; m_phase = 2;
                end
                2: begin
                    if (din_valid) begin
                        m_bits.push_back(int'(din));
                        m_wcnt++;
                        if (model_match()) begin
                            m_det = 1'b1;
                            if (m_cnt == CNT_MAX) m_ovf = 1'b1;
                            else m_cnt++;
                            if (!OVL) m_bits.delete();
                        end
                    end
                    if (stop || (m_win != 0 && m_wcnt == m_win)) m_phase = 3;
                end
                default: m_phase = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        chk("busy", int'(busy), int'(m_phase == 1 || m_phase == 2));
        chk("done", int'(done), int'(m_phase == 3));
        chk("detected", int'(detected), int'(m_det));
        chk("det_count", int'(det_count), m_cnt);
        chk("overflow", int'(overflow), int'(m_ovf));
        if (detected) det_pulses++;
        if (done) done_pulses++;
    end

    task automatic cyc(input bit we, input bit st, input bit sp, input bit v, input bit d);
        cfg_we = we; start = st; stop = sp; din_valid = v; din = d;
        @(negedge clk);
        #1;
        cfg_we = 1'b0; start = 1'b0; stop = 1'b0; din_valid = 1'b0; din = 1'b0;
    endtask

    task automatic send_bits(input logic [15:0] b, input int n);
        for (int i = n - 1; i >= 0; i--) cyc(1'b0, 1'b0, 1'b0, 1'b1, b[i]);
    endtask

    task automatic set_cfg(input logic [7:0] p, input logic [3:0] l, input logic [15:0] w);
        cfg_pattern = p; cfg_len = l; cfg_window = w;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int dp0, dn0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_det_count", int'(det_count), 0);
        chk("rst_done", int'(done), 0);
        rst_n = 1'b1;
        cyc(0, 0, 0, 0, 0);

        // Basic match
        set_cfg(8'b10010, 4'd5, 16'd5);
        cyc(1, 0, 0, 0, 0);
        dp0 = det_pulses; dn0 = done_pulses;
        cyc(0, 1, 0, 0, 0);
        chk("t1_armed_busy", int'(busy), 1);
        cyc(0, 0, 0, 0, 0);
        send_bits(16'b10010, 5);
        chk("t1_detected", int'(detected), 1);
        chk("t1_done", int'(done), 1);
        chk("t1_det_count", int'(det_count), 1);
        cyc(0, 0, 0, 0, 0);
        chk("t1_det_pulses", det_pulses - dp0, 1);
        chk("t1_done_pulses", done_pulses - dn0, 1);

        // Overlapping occurrences; load and start together
        set_cfg(8'b10010, 4'd5, 16'd10);
        cyc(1, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        send_bits(16'b0010010010, 10);
        chk("t2_det_count", int'(det_count), EXP_OVL);
        chk("t2_done", int'(done), 1);
        cyc(0, 0, 0, 0, 0);

        // No match
        set_cfg(8'b10010, 4'd5, 16'd5);
        cyc(1, 1, 0, 0, 0);
        dp0 = det_pulses; dn0 = done_pulses;
        cyc(0, 0, 0, 0, 0);
        send_bits(16'b11011, 5);
        cyc(0, 0, 0, 0, 0);
        chk("t3_det_pulses", det_pulses - dp0, 0);
        chk("t3_done_pulses", done_pulses - dn0, 1);
        chk("t3_det_count", int'(det_count), 0);

        // Saturation and sticky overflow
        set_cfg(8'h01, 4'd1, 16'd0);
        cyc(1, 1, 0, 0, 0);
        dp0 = det_pulses; dn0 = done_pulses;
        cyc(0, 0, 0, 0, 0);
        send_bits(16'b11111, 5);
        cyc(0, 0, 1, 0, 0);
        chk("t4_done", int'(done), 1);
        chk("t4_det_count", int'(det_count), 3);
        chk("t4_overflow", int'(overflow), 1);
        cyc(0, 0, 0, 0, 0);
        chk("t4_overflow_hold", int'(overflow), 1);
        chk("t4_det_pulses", det_pulses - dp0, 5);
        chk("t4_done_pulses", done_pulses - dn0, 1);

        // Reset mid-window
        set_cfg(8'b10010, 4'd5, 16'd0);
        cyc(1, 1, 0, 0, 0);
        dn0 = done_pulses;
        cyc(0, 0, 0, 0, 0);
        send_bits(16'b100, 3);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_busy", int'(busy), 0);
        chk("t5_rst_done", int'(done), 0);
        chk("t5_rst_detected", int'(detected), 0);
        chk("t5_rst_det_count", int'(det_count), 0);
        chk("t5_rst_overflow", int'(overflow), 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        chk("t5_no_done", done_pulses - dn0, 0);
        set_cfg(8'b10010, 4'd5, 16'd0);
        cyc(1, 1, 0, 0, 0);
        dp0 = det_pulses;
        cyc(0, 0, 0, 0, 0);
        send_bits(16'b10, 2);
        chk("t5_no_detect", det_pulses - dp0, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0);

        // Configuration write and start ignored while running
        set_cfg(8'b10010, 4'd5, 16'd10);
        cyc(1, 1, 0, 0, 0);
        dp0 = det_pulses;
        cyc(0, 0, 0, 0, 0);
        send_bits(16'b10, 2);
        set_cfg(8'h00, 4'd5, 16'd10);
        cyc(1, 1, 0, 0, 0);
        chk("t6_busy", int'(busy), 1);
        send_bits(16'b010, 3);
        chk("t6_detected", int'(detected), 1);
        chk("t6_det_count", int'(det_count), 1);
        cyc(0, 0, 1, 1, 1);
        chk("t6_stop_done", int'(done), 1);
        chk("t6_det_pulses", det_pulses - dp0, 1);
        cyc(0, 0, 0, 0, 0);

        // Length 0 loads as 1
        set_cfg(8'h01, 4'd0, 16'd3);
        cyc(1, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        send_bits(16'b101, 3);
        chk("t7_det_count", int'(det_count), 2);
        chk("t7_done", int'(done), 1);
        cyc(0, 0, 0, 0, 0);

        // Length above MAX_LEN loads as MAX_LEN
        set_cfg(8'hA5, 4'd15, 16'd0);
        cyc(1, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        send_bits(16'b10100101, 8);
        chk("t8_detected", int'(detected), 1);
        cyc(0, 0, 1, 0, 0);
        chk("t8_det_count", int'(det_count), 1);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/seq_window_ctrl.md
SEQ_WINDOW_CTRL -- requirements
Module: seq_window_ctrl

Interface
REQ-001 Parameter MAX_LEN, default 8: maximum pattern length in bits.
REQ-002 Parameter CNT_W, default 8: width of the detection counter.
REQ-003 Parameter WIN_W, default 16: width of the window length.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 cfg_we  input  1  configuration write strobe.
REQ-007 cfg_pattern  input  MAX_LEN  pattern; bit [len-1] is the first received bit, bit [0] the last.
REQ-008 cfg_len  input  4  pattern length.
REQ-009 cfg_window  input  WIN_W  number of valid bits per window; 0 = unbounded.
REQ-010 start  input  1  one-cycle request to open a window.
REQ-011 stop  input  1  one-cycle request to close the window early.
REQ-012 din  input  1  serial data bit.
REQ-013 din_valid  input  1  qualifies din.
REQ-014 busy  output  1  high in ARM and RUN.
REQ-015 detected  output  1  one-cycle match pulse.
REQ-016 det_count  output  CNT_W  matches in the current or last window.
REQ-017 overflow  output  1  sticky flag; det_count saturated.
REQ-018 done  output  1  one-cycle pulse at window close.

Function
REQ-019 FSM states: IDLE, ARM, RUN and DONE.
REQ-020 Transitions:
- IDLE->ARM on start.
- ARM->RUN unconditionally, next cycle.
- RUN->DONE when the window bit count reaches a nonzero cfg_window, or on stop.
- DONE->IDLE unconditionally.
REQ-021 Configuration registers load on cfg_we only in IDLE; cfg_we is ignored in all other states.
REQ-022 cfg_len loading: 0 loads as 1; values above MAX_LEN load as MAX_LEN.
REQ-023 start is ignored outside IDLE.
REQ-024 A simultaneous start and cfg_we in IDLE loads the configuration, then arms with the new configuration.
REQ-025 ARM actions: clear the history shift register, fill counter, window bit counter, det_count and overflow.
REQ-026 In RUN, each din_valid shifts din into history LSB-first-newest, increments the fill counter (saturating at MAX_LEN) and increments the window bit counter.
REQ-027 Match condition:
- a valid bit is accepted in RUN;
- the fill counter, including that bit, is at least len;
- the low len bits of history, including that bit, equal the low len bits of the pattern.
REQ-028 detected is registered: it asserts on the cycle after the completing bit is sampled and lasts exactly one cycle.
REQ-029 Each match increments det_count, which saturates at all-ones.
REQ-030 A match with det_count already at all-ones sets overflow; overflow holds until the next ARM or reset.
REQ-031 A bit that completes a match and the window on the same cycle is counted, detected pulses, and the FSM enters DONE.
REQ-032 A stop and a valid bit on the same cycle: the bit is processed, then the window closes.
REQ-033 done pulses for one cycle in DONE.
REQ-034 det_count and overflow hold their values through DONE and IDLE until the next ARM.
REQ-035 din_valid outside RUN is ignored.
REQ-036 The window bit counter does not wrap: it stops at cfg_window; with cfg_window = 0 it saturates at all-ones.

Reset
REQ-037 Reset forces, immediately and independent of clk: FSM to IDLE, busy=0, detected=0, done=0, det_count=0, overflow=0, and history, fill and window counters to 0.
REQ-038 Reset values of the configuration registers: pattern=0, len=1, window=0.
REQ-039 Reset asserted mid-window aborts the window without a done pulse.

Configuration
REQ-040 Macro DETECT_OVERLAP_EN.
- Defined: a match leaves history and the fill counter intact, so overlapping matches are detected.
- Undefined: a match clears the fill counter to 0, so the next match needs len fresh bits (non-overlapping).

Verification
REQ-041 Basic match: pattern=5'b10010, len=5, window=5; start, then bits 1,0,0,1,0 -> one detected pulse after the 5th bit, det_count=1, then done.
REQ-042 Overlap: pattern 10010, len 5, window 10, bits 0010010010.
- DETECT_OVERLAP_EN defined -> det_count=2.
- Undefined -> det_count=1.
REQ-043 No match: bits 1,1,0,1,1 with window=5 -> detected never asserts, det_count=0, done pulses once.
REQ-044 Saturation: CNT_W=2, len=1, pattern=1, window=0; drive 5 valid 1s, then stop -> det_count=3, overflow=1, done pulses once.
REQ-045 Reset mid-window: pattern 10010; drive 1,0,0, then assert reset -> all outputs 0 at once, no done pulse. Release reset, start, drive 1,0 -> no detection.
REQ-046 Ignored requests while busy: cfg_we with pattern=0 and start pulsed in RUN -> pattern unchanged, no re-arm, det_count unaffected.
